// File: rtl/ls_preloader.sv
// LocalStore preloader: packs 32-bit source words into 128-bit quadwords and writes them over the odd pipe's preload port.
// Optional macro LS_PRELOAD_CHECKSUM_EN enables the XOR checksum of written words.
module ls_preloader #(
  parameter int MAX_QW = 2048
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:14]  load_base,
  input  logic [0:11]  load_len,
  input  logic         in_valid,
  input  logic [0:31]  in_word,
  output logic         in_ready,
  output logic         preload_LS_en,
  output logic [0:14]  preload_LS_addr,
  output logic [0:127] preload_LS_data,
  output logic         busy,
  output logic         done,
  output logic [0:31]  checksum
);

  localparam logic [11:0] MAX_LEN = 12'(MAX_QW);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t      state;
  logic [14:0] addr_cur;
  logic [11:0] len_q;
  logic [11:0] qw_cnt;
  logic [1:0]  word_idx;
  logic [0:95] qw_buf;
  logic        accept;
  logic [11:0] len_eff;

  function automatic logic [11:0] clamp_len(input logic [11:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  assign accept  = in_valid & in_ready;
  assign len_eff = clamp_len(load_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      addr_cur        <= '0;
      len_q           <= '0;
      qw_cnt          <= '0;
      word_idx        <= '0;
      qw_buf          <= '0;
      in_ready        <= 1'b0;
      preload_LS_en   <= 1'b0;
      preload_LS_addr <= '0;
      preload_LS_data <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      preload_LS_en <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr_cur <= load_base & 15'h7FF0;
            len_q    <= len_eff;
            qw_cnt   <= '0;
            word_idx <= '0;
            busy     <= 1'b1;
            if (len_eff == 12'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
            end
          end
        end
        FILL: begin
          if (accept) begin
            word_idx <= word_idx + 2'd1;
            case (word_idx)
              2'd0: qw_buf[0:31]  <= in_word;
              2'd1: qw_buf[32:63] <= in_word;
              2'd2: qw_buf[64:95] <= in_word;
              default: begin
                // The output registers only change here, so they hold between writes.
                preload_LS_data <= {qw_buf, in_word};
                preload_LS_addr <= addr_cur;
                preload_LS_en   <= 1'b1;
                in_ready        <= 1'b0;
                state           <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          addr_cur <= addr_cur + 15'd16;
          qw_cnt   <= qw_cnt + 12'd1;
          if (qw_cnt + 12'd1 == len_q) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LS_PRELOAD_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      checksum <= '0;
    else if (state == IDLE && start)
      checksum <= '0;
    else if (state == WRITE)
      checksum <= checksum ^ preload_LS_data[0:31] ^ preload_LS_data[32:63]
                           ^ preload_LS_data[64:95] ^ preload_LS_data[96:127];
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_ls_preloader.sv
// Directed self-checking bench for ls_preloader: alignment, wrap, stalls, zero length, start-while-busy, reset mid-load.
module tb_ls_preloader;

  logic         clk = 1'b0;
  logic         rst_n, start, in_valid;
  logic [0:14]  load_base;
  logic [0:11]  load_len;
  logic [0:31]  in_word;
  logic         in_ready, preload_LS_en, busy, done;
  logic [0:14]  preload_LS_addr;
  logic [0:127] preload_LS_data;
  logic [0:31]  checksum;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_n  = 0;
  int done_n = 0;
  int done_cyc = 0;
  logic [14:0]  wr_addr [64];
  logic [127:0] wr_data [64];
  int           wr_cyc  [64];

  always #5 clk = ~clk;

  ls_preloader #(.MAX_QW(2048)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_base(load_base), .load_len(load_len),
    .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .preload_LS_en(preload_LS_en), .preload_LS_addr(preload_LS_addr),
    .preload_LS_data(preload_LS_data), .busy(busy), .done(done), .checksum(checksum)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (preload_LS_en && wr_n < 64) begin
      wr_addr[wr_n] = preload_LS_addr;
      wr_data[wr_n] = preload_LS_data;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] exp_ck(input logic [31:0] v);
`ifdef LS_PRELOAD_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int g = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_word_timeout: in_ready=%0b required 1", in_ready);
    end
    step();
  endtask

  task automatic go(input logic [14:0] base, input logic [11:0] len, output int s);
    load_base = base;
    load_len  = len;
    start     = 1'b1;
    step();
    start = 1'b0;
    s     = cyc;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 100) begin
      step();
      g++;
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle: busy=%0b required 0", busy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    total++; if (preload_LS_en !== 1'b0) begin bad++; $display("FAIL rst_en: got %0b want 0", preload_LS_en); end
    total++; if (preload_LS_addr !== 15'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", preload_LS_addr); end
    total++; if (preload_LS_data !== 128'h0) begin bad++; $display("FAIL rst_data: got %h want 0", preload_LS_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
    total++; if (checksum !== 32'h0) begin bad++; $display("FAIL rst_checksum: got %h want 0", checksum); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int s, w0;
    w0 = wr_n;
    go(15'h0010, 12'd1, s);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %0b want 1", busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %0b want 1", in_ready); end
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    in_valid = 1'b0;
    wait_idle();
    total++; if (cyc !== s + 6) begin bad++; $display("FAIL single_idle_cyc: got %0d want %0d", cyc, s + 6); end
    total++; if (wr_n - w0 !== 1) begin bad++; $display("FAIL single_nwr: got %0d want 1", wr_n - w0); end
    total++; if (wr_addr[w0] !== 15'h0010) begin bad++; $display("FAIL single_addr: got %h want 0010", wr_addr[w0]); end
    total++; if (wr_data[w0] !== 128'h11111111_22222222_33333333_44444444) begin
      bad++; $display("FAIL single_data: got %h", wr_data[w0]); end
    total++; if (wr_cyc[w0] !== s + 4) begin bad++; $display("FAIL single_wr_cyc: got %0d want %0d", wr_cyc[w0], s + 4); end
    total++; if (done_cyc !== s + 5) begin bad++; $display("FAIL single_done_cyc: got %0d want %0d", done_cyc, s + 5); end
    total++; if (preload_LS_data !== 128'h11111111_22222222_33333333_44444444) begin
      bad++; $display("FAIL single_hold: got %h", preload_LS_data); end
    total++; if (checksum !== exp_ck(32'h44444444)) begin
      bad++; $display("FAIL single_checksum: got %h want %h", checksum, exp_ck(32'h44444444)); end
  endtask

  task automatic test_misaligned();
    int s, w0;
    w0 = wr_n;
    go(15'h001F, 12'd2, s);
    for (int i = 0; i < 8; i++) send_word(32'h1 << i);
    in_valid = 1'b0;
    wait_idle();
    total++; if (wr_n - w0 !== 2) begin bad++; $display("FAIL mis_nwr: got %0d want 2", wr_n - w0); end
    total++; if (wr_addr[w0] !== 15'h0010) begin bad++; $display("FAIL mis_addr0: got %h want 0010", wr_addr[w0]); end
    total++; if (wr_addr[w0+1] !== 15'h0020) begin bad++; $display("FAIL mis_addr1: got %h want 0020", wr_addr[w0+1]); end
    total++; if (wr_data[w0+1] !== 128'h00000010_00000020_00000040_00000080) begin
      bad++; $display("FAIL mis_data1: got %h", wr_data[w0+1]); end
    total++; if (wr_cyc[w0+1] - wr_cyc[w0] !== 5) begin
      bad++; $display("FAIL mis_rate: got %0d want 5", wr_cyc[w0+1] - wr_cyc[w0]); end
    total++; if (checksum !== exp_ck(32'h000000FF)) begin
      bad++; $display("FAIL mis_checksum: got %h want %h", checksum, exp_ck(32'h000000FF)); end
  endtask

  task automatic test_wrap();
    int s, w0;
    logic [31:0] w [8];
    w = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000000,
          32'h0000FFFF, 32'hFFFF0000, 32'h12345678, 32'h12345678};
    w0 = wr_n;
    go(15'h7FF0, 12'd2, s);
    for (int i = 0; i < 8; i++) send_word(w[i]);
    in_valid = 1'b0;
    wait_idle();
    total++; if (wr_addr[w0] !== 15'h7FF0) begin bad++; $display("FAIL wrap_addr0: got %h want 7ff0", wr_addr[w0]); end
    total++; if (wr_addr[w0+1] !== 15'h0000) begin bad++; $display("FAIL wrap_addr1: got %h want 0000", wr_addr[w0+1]); end
    total++; if (wr_data[w0] !== 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000) begin
      bad++; $display("FAIL wrap_data0: got %h", wr_data[w0]); end
    total++; if (checksum !== exp_ck(32'hFFFFFFFF)) begin
      bad++; $display("FAIL wrap_checksum: got %h want %h", checksum, exp_ck(32'hFFFFFFFF)); end
  endtask

  task automatic test_stall();
    int s, w0, n;
    w0 = wr_n;
    go(15'h0100, 12'd1, s);
    send_word(32'h01010101);
    send_word(32'h02020202);
    in_valid = 1'b0;
    in_word  = 32'hBADBAD00;
    for (int i = 0; i < 7; i++) begin
      step();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready[%0d]: got %0b want 1", i, in_ready); end
      total++; if (preload_LS_en !== 1'b0) begin bad++; $display("FAIL stall_en[%0d]: got %0b want 0", i, preload_LS_en); end
      total++; if (preload_LS_data !== 128'h0000FFFF_FFFF0000_12345678_12345678) begin
        bad++; $display("FAIL stall_data[%0d]: got %h", i, preload_LS_data); end
    end
    send_word(32'h04040404);
    send_word(32'h08080808);
    n = cyc;
    in_valid = 1'b0;
    wait_idle();
    total++; if (wr_n - w0 !== 1) begin bad++; $display("FAIL stall_nwr: got %0d want 1", wr_n - w0); end
    total++; if (wr_cyc[w0] !== n) begin bad++; $display("FAIL stall_wr_cyc: got %0d want %0d", wr_cyc[w0], n); end
    total++; if (wr_addr[w0] !== 15'h0100) begin bad++; $display("FAIL stall_addr: got %h want 0100", wr_addr[w0]); end
    total++; if (wr_data[w0] !== 128'h01010101_02020202_04040404_08080808) begin
      bad++; $display("FAIL stall_data: got %h", wr_data[w0]); end
    total++; if (checksum !== exp_ck(32'h0F0F0F0F)) begin
      bad++; $display("FAIL stall_checksum: got %h want %h", checksum, exp_ck(32'h0F0F0F0F)); end
  endtask

  task automatic test_zero_and_busy_start();
    int s, w0, d0;
    w0 = wr_n;
    d0 = done_n;
    go(15'h0050, 12'd0, s);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done: got %0b want 1", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL zero_ready: got %0b want 0", in_ready); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse: got %0b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy: got %0b want 0", busy); end
    total++; if (wr_n !== w0) begin bad++; $display("FAIL zero_nwr: got %0d want %0d", wr_n, w0); end
    total++; if (checksum !== 32'h0) begin bad++; $display("FAIL zero_checksum: got %h want 0", checksum); end
    go(15'h0200, 12'd1, s);
    send_word(32'hAAAA0001);
    send_word(32'hAAAA0002);
    load_base = 15'h0400;
    load_len  = 12'd3;
    start     = 1'b1;
    send_word(32'hAAAA0003);
    start = 1'b0;
    send_word(32'hAAAA0004);
    in_valid = 1'b0;
    wait_idle();
    total++; if (wr_n - w0 !== 1) begin bad++; $display("FAIL busy_start_nwr: got %0d want 1", wr_n - w0); end
    total++; if (wr_addr[w0] !== 15'h0200) begin bad++; $display("FAIL busy_start_addr: got %h want 0200", wr_addr[w0]); end
    total++; if (done_n - d0 !== 2) begin bad++; $display("FAIL busy_start_dones: got %0d want 2", done_n - d0); end
  endtask

  task automatic test_reset_mid_load();
    int s, w0;
    w0 = wr_n;
    go(15'h0300, 12'd4, s);
    for (int i = 0; i < 10; i++) send_word(32'h30000000 + i);
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %0b want 0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
    total++; if (preload_LS_addr !== 15'h0) begin bad++; $display("FAIL mid_rst_addr: got %h want 0", preload_LS_addr); end
    total++; if (preload_LS_data !== 128'h0) begin bad++; $display("FAIL mid_rst_data: got %h want 0", preload_LS_data); end
    total++; if (checksum !== 32'h0) begin bad++; $display("FAIL mid_rst_checksum: got %h want 0", checksum); end
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    total++; if (wr_n - w0 !== 2) begin bad++; $display("FAIL mid_nwr: got %0d want 2", wr_n - w0); end
    total++; if (wr_addr[w0+1] !== 15'h0310) begin bad++; $display("FAIL mid_addr1: got %h want 0310", wr_addr[w0+1]); end
    go(15'h0040, 12'd1, s);
    send_word(32'hC0000001);
    send_word(32'hC0000002);
    send_word(32'hC0000004);
    send_word(32'hC0000008);
    in_valid = 1'b0;
    wait_idle();
    total++; if (wr_n - w0 !== 3) begin bad++; $display("FAIL mid_new_nwr: got %0d want 3", wr_n - w0); end
    total++; if (wr_addr[w0+2] !== 15'h0040) begin bad++; $display("FAIL mid_new_addr: got %h want 0040", wr_addr[w0+2]); end
    total++; if (wr_data[w0+2] !== 128'hC0000001_C0000002_C0000004_C0000008) begin
      bad++; $display("FAIL mid_new_data: got %h", wr_data[w0+2]); end
    total++; if (checksum !== exp_ck(32'h0000000F)) begin
      bad++; $display("FAIL mid_new_checksum: got %h want %h", checksum, exp_ck(32'h0000000F)); end
  endtask

  initial begin
    start     = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    load_base = '0;
    load_len  = '0;
    test_reset();
    test_single();
    test_misaligned();
    test_wrap();
    test_stall();
    test_zero_and_busy_start();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ls_preloader.md
# ls_preloader

Streams a program/data image into the odd pipe's LocalStore over its preload port before execution starts. Accepts 32-bit words from a host/testbench source with a valid/ready handshake and packs four words into one 128-bit quadword. Writes each quadword to consecutive quadword-aligned LocalStore addresses and holds the core pipeline while loading is in progress. It is the writer that drives the `preload_LS_en` / `preload_LS_addr` / `preload_LS_data` inputs of the odd pipe.

## Interface
- `MAX_QW`, default 2048: maximum quadwords per load; equals LocalStore capacity of 32 KB / 16 B.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle load request; sampled only in IDLE.
- `load_base`  in  [0:14]  LocalStore byte address of the first quadword; bits [11:14] ignored and treated as 0.
- `load_len`  in  [0:11]  number of quadwords to write, 0..MAX_QW.
- `in_valid`  in  1  source word valid.
- `in_word`  in  [0:31]  source word.
- `in_ready`  out  1  block accepts `in_word` this cycle.
- `preload_LS_en`  out  1  LocalStore write strobe.
- `preload_LS_addr`  out  [0:14]  LocalStore byte address, quadword-aligned.
- `preload_LS_data`  out  [0:127]  quadword to write.
- `busy`  out  1  load in progress; also used as the core hold/stall.
- `done`  out  1  one-cycle pulse when the load completes.
- `checksum`  out  [0:31]  XOR of all written words; see Configuration.

## Operation
- FSM states: IDLE, FILL, WRITE, DONE.
- **IDLE**
  - `start`=1 latches the base address with bits [11:14] zeroed, latches `load_len`, and clears the word index, quadword counter and checksum.
  - If `load_len`=0, go to DONE; otherwise go to FILL.
- **FILL**
  - `in_ready`=1.
  - A word is accepted when `in_valid` and `in_ready` are both high.
  - Word k of the quadword (k=0..3) is placed at bits [32k : 32k+31]. The first word is the most significant, matching the big-endian numbering of the bus.
  - On acceptance of word 3, go to WRITE.
- **WRITE**
  - Lasts exactly one cycle: `preload_LS_en`=1, with the registered address and data.
  - At the end of the cycle: address += 16, modulo 2^15, so 0x7FF0 wraps to 0x0000; the quadword counter increments.
  - If counter+1 == latched length, go to DONE; otherwise go to FILL.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in FILL, WRITE and DONE; `busy`=0 in IDLE.
- `start` is ignored while `busy`=1.
- `load_len` > MAX_QW is clamped to MAX_QW.
- `in_ready`=0 outside FILL. Source words presented then are not consumed.
- `in_valid` deasserting mid-quadword stalls FILL indefinitely; the partial quadword is retained.
- `preload_LS_data` and `preload_LS_addr` hold their last values when `preload_LS_en`=0.

## Timing
- Reset (`rst_n`=0, any time): state IDLE; all outputs 0, including `preload_LS_addr`, `preload_LS_data` and `checksum`.
- Reset mid-load: the partial quadword is discarded and no write is issued. LocalStore contents already written are not rolled back.
- `start` high at edge t: FILL from cycle t+1; `in_ready` high in cycle t+1.
- Word 3 accepted at edge n: `preload_LS_en` high during cycle n+1; next FILL in cycle n+2.
- Sustained throughput is 5 cycles per quadword with `in_valid` held high.
- The last WRITE at cycle w is followed by `done` at cycle w+1 and `busy`=0 at cycle w+2.
- `load_len`=0: `done` at t+1, no writes.

## Configuration
- Macro: `LS_PRELOAD_CHECKSUM_EN`.
- **Defined**
  - `checksum` is updated in the WRITE cycle with the XOR of the four words of the quadword being written.
  - The new value is visible the cycle after WRITE.
  - `checksum` is cleared on an accepted `start` and holds after DONE until the next `start`.
- **Undefined**
  - `checksum` is tied to 0 and the accumulator logic is removed.
  - All other behaviour is identical.

## Test plan
- **Single quadword:** `load_base`=0x0010, `load_len`=1, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with `in_valid` held high.
  - One write: addr=0x0010, data=0x11111111_22222222_33333333_44444444.
  - `done` 6 cycles after `start`.
  - `checksum`=0x44444444 when the macro is defined.
- **Misaligned base:** `load_base`=0x001F, `load_len`=2.
  - Writes at 0x0010, then 0x0020.
- **Wrap-around:** `load_base`=0x7FF0, `load_len`=2.
  - Writes at 0x7FF0, then 0x0000.
- **Source stall:** `in_valid` dropped for 7 cycles after word 1.
  - `in_ready` stays high, no write occurs, and the assembled data is unchanged.
  - The write happens 1 cycle after word 3 is accepted.
- **Zero length / start while busy:**
  - `load_len`=0: `done` at t+1 with no `preload_LS_en`.
  - A second `start` mid-load is ignored; the load continues with the original length.
- **Reset mid-load:** `rst_n` asserted after 2 words of quadword 3.
  - All outputs 0 immediately, no write for quadword 3.
  - A new `start` afterwards begins a fresh load at its own `load_base`.
